// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
// Two-stage read: grant/select registered, then bypass/XZR resolution into the response.
module regfile_read_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [5*N_REQ-1:0]   addr,
  output logic [N_REQ-1:0]     gnt,
  output logic [4:0]           rf_sel,
  input  logic [DATA_W-1:0]    rf_rdata,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [DATA_W-1:0]    rsp_data
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  r_ptr;
  logic [4:0]        r_rf_sel;
  logic [PTR_W-1:0]  r_s1_owner;
  logic              r_s1_valid;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_any;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  w_gnt;
  logic [N_REQ-1:0]  w_owner_oh;
  logic [4:0]        w_win_addr;
  logic [DATA_W-1:0] w_result;

  // Scan from r_ptr upward, wrapping, and take the first pending request.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_any && req[(int'(r_ptr) + i) % N_REQ]) begin
        w_any = 1'b1;
        w_win = PTR_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
    if (reset) begin
      w_any = 1'b0;
      w_win = '0;
    end
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  assign w_ptr_nxt  = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
  assign w_win_addr = addr[5*int'(w_win) +: 5];

  always_comb begin
    w_owner_oh = '0;
    w_owner_oh[r_s1_owner] = 1'b1;
  end

  // XZR beats bypass, so a write to r31 can never leak into a read.
  always_comb begin
    if (r_rf_sel == 5'd31)                  w_result = '0;
    else if (wr_en && wr_addr == r_rf_sel)  w_result = wr_data;
    else                                    w_result = rf_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rf_sel    <= 5'd0;
      r_s1_owner  <= '0;
      r_s1_valid  <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_s1_valid <= w_any;
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_rf_sel   <= w_win_addr;
        r_s1_owner <= w_win;
      end
      r_rsp_valid <= r_s1_valid ? w_owner_oh : '0;
      if (r_s1_valid) r_rsp_data <= w_result;
    end
  end

  assign gnt       = w_gnt;
  assign rf_sel    = r_rf_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - table-driven directed bench for regfile_read_arbiter
module tb_regfile_read_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 64;
  localparam logic [19:0] A_RR = {5'd13, 5'd12, 5'd11, 5'd10};

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [5*N_REQ-1:0]   addr;
  logic [N_REQ-1:0]     gnt;
  logic [4:0]           rf_sel;
  logic [DATA_W-1:0]    rf_rdata;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [N_REQ-1:0]     rsp_valid;
  logic [DATA_W-1:0]    rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt),
    .rf_sel(rf_sel), .rf_rdata(rf_rdata), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  function automatic logic [DATA_W-1:0] rf_model(input logic [4:0] r);
    case (r)
      5'd5:    return 64'h1234;
      5'd7:    return 64'hAAAA;
      5'd31:   return 64'hFFFF;
      default: return 64'hA000 + 64'(r);
    endcase
  endfunction

  assign rf_rdata = rf_model(rf_sel);

  typedef struct {
    logic [3:0]  req;
    logic [19:0] addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  gnt;
    logic [4:0]  sel;
    logic [3:0]  rv;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [3:0] rq, input logic [19:0] ad, input logic we,
                              input logic [4:0] wa, input logic [63:0] wd, input logic [3:0] g,
                              input logic [4:0] s, input logic [3:0] v, input logic [63:0] d);
    vec_t t;
    t.req = rq; t.addr = ad; t.wr_en = we; t.wr_addr = wa; t.wr_data = wd;
    t.gnt = g; t.sel = s; t.rv = v; t.rd = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [4:0] s,
                               input logic [3:0] v, input logic [63:0] d);
    check({tag, " gnt"}, 64'(gnt), 64'(g));
    check({tag, " rf_sel"}, 64'(rf_sel), 64'(s));
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(v));
    check({tag, " rsp_data"}, rsp_data, d);
  endtask

  task automatic drive(input logic [3:0] rq, input logic [19:0] ad, input logic we,
                       input logic [4:0] wa, input logic [63:0] wd);
    req = rq; addr = ad; wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  initial begin
    // single read, round-robin, skip fairness, bypass, XZR, same-cycle write, back-to-back
    tbl[0]  = mk(4'b0001, {15'd0, 5'd5}, 0, 0, 0,          4'b0001, 5'd0,  4'b0000, 64'h0);
    tbl[1]  = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd5,  4'b0000, 64'h0);
    tbl[2]  = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd5,  4'b0001, 64'h1234);
    tbl[3]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0010, 5'd5,  4'b0000, 64'h1234);
    tbl[4]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0100, 5'd11, 4'b0000, 64'h1234);
    tbl[5]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b1000, 5'd12, 4'b0010, 64'hA00B);
    tbl[6]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0001, 5'd13, 4'b0100, 64'hA00C);
    tbl[7]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0010, 5'd10, 4'b1000, 64'hA00D);
    tbl[8]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0100, 5'd11, 4'b0001, 64'hA00A);
    tbl[9]  = mk(4'b1111, A_RR, 0, 0, 0,                   4'b1000, 5'd12, 4'b0010, 64'hA00B);
    tbl[10] = mk(4'b1111, A_RR, 0, 0, 0,                   4'b0001, 5'd13, 4'b0100, 64'hA00C);
    tbl[11] = mk(4'b0010, A_RR, 0, 0, 0,                   4'b0010, 5'd10, 4'b1000, 64'hA00D);
    tbl[12] = mk(4'b0011, A_RR, 0, 0, 0,                   4'b0001, 5'd11, 4'b0001, 64'hA00A);
    tbl[13] = mk(4'b0011, A_RR, 0, 0, 0,                   4'b0010, 5'd10, 4'b0010, 64'hA00B);
    tbl[14] = mk(4'b0001, {15'd0, 5'd7}, 0, 0, 0,          4'b0001, 5'd11, 4'b0001, 64'hA00A);
    tbl[15] = mk(4'b0000, A_RR, 1, 5'd7, 64'h5555,         4'b0000, 5'd7,  4'b0010, 64'hA00B);
    tbl[16] = mk(4'b0001, {15'd0, 5'd7}, 0, 0, 0,          4'b0001, 5'd7,  4'b0001, 64'h5555);
    tbl[17] = mk(4'b0000, A_RR, 1, 5'd8, 64'h5555,         4'b0000, 5'd7,  4'b0000, 64'h5555);
    tbl[18] = mk(4'b0001, {15'd0, 5'd31}, 0, 0, 0,         4'b0001, 5'd7,  4'b0001, 64'hAAAA);
    tbl[19] = mk(4'b0000, A_RR, 1, 5'd31, 64'h9,           4'b0000, 5'd31, 4'b0000, 64'hAAAA);
    tbl[20] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd31, 4'b0001, 64'h0);
    tbl[21] = mk(4'b0001, {15'd0, 5'd7}, 1, 5'd7, 64'h7777, 4'b0001, 5'd31, 4'b0000, 64'h0);
    tbl[22] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd7,  4'b0000, 64'h0);
    tbl[23] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd7,  4'b0001, 64'hAAAA);
    tbl[24] = mk(4'b0100, A_RR, 0, 0, 0,                   4'b0100, 5'd7,  4'b0000, 64'hAAAA);
    tbl[25] = mk(4'b0100, {5'd13, 5'd13, 5'd11, 5'd10}, 0, 0, 0, 4'b0100, 5'd12, 4'b0000, 64'hAAAA);
    tbl[26] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd13, 4'b0100, 64'hA00C);
    tbl[27] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd13, 4'b0100, 64'hA00D);
    tbl[28] = mk(4'b0000, A_RR, 0, 0, 0,                   4'b0000, 5'd13, 4'b0000, 64'hA00D);

    reset = 1'b1;
    drive(4'b1111, A_RR, 1'b0, 5'd0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset gnt forced", 64'(gnt), 64'h0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(tbl[i].req, tbl[i].addr, tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data);
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].rv, tbl[i].rd);
    end

    // reset mid-flight: ptr is 3, grant requester 1 so ptr would become 2
    @(negedge clk);
    drive(4'b0010, A_RR, 1'b0, 5'd0, 64'h0);
    #1;
    check("midrst T gnt", 64'(gnt), 64'b0010);
    @(negedge clk);
    reset = 1'b1;
    drive(4'b1111, A_RR, 1'b0, 5'd0, 64'h0);
    #1;
    check("midrst T+1 gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("midrst T+2", 4'b0001, 5'd0, 4'b0000, 64'h0);
    @(negedge clk);
    drive(4'b0000, A_RR, 1'b0, 5'd0, 64'h0);
    #1;
    check_outputs("midrst T+3", 4'b0000, 5'd10, 4'b0000, 64'h0);
    @(negedge clk);
    #1;
    check_outputs("midrst T+4", 4'b0000, 5'd10, 4'b0001, 64'hA00A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
Round-robin arbiter that time-shares one register-file read port among N_REQ requesters, for example the decode-stage read ports and the debug/exception path. It drives the 5-bit select of the 32-to-1 read mux tree and captures the selected data. It applies write-bypass and the ARM XZR rule (register 31 reads as zero). The read path is fully pipelined, so one grant can be issued every cycle.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 64, register width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  request vector, bit i = requester i wants a read
addr  input  5*N_REQ  register number per requester, requester i at bits [5i+4:5i]
gnt  output  N_REQ  one-hot combinational grant for the current cycle, all-zero if no req
rf_sel  output  5  registered select to the read mux tree
rf_rdata  input  DATA_W  data from the mux tree for the current rf_sel
wr_en  input  1  writeback write enable, same cycle as register-file write
wr_addr  input  5  writeback register number
wr_data  input  DATA_W  writeback data
rsp_valid  output  N_REQ  one-hot, response for requester i is valid this cycle
rsp_data  output  DATA_W  read result accompanying rsp_valid

Behaviour:
- Reset values:
  - ptr = 0, where ptr is the highest-priority requester index.
  - rf_sel = 0, rsp_valid = 0, rsp_data = 0.
  - Stage-1 valid and owner registers = 0.
- Arbitration, cycle T (combinational):
  - Scan req starting at index ptr, ascending and wrapping modulo N_REQ.
  - The first set bit k wins and gnt[k] = 1. At most one bit of gnt is high.
  - gnt is forced to 0 while reset is high.
- Pointer update at the end of T: if any grant was issued, ptr <= (k+1) mod N_REQ. Otherwise ptr holds.
- Requester protocol:
  - A requester holds req and addr stable until it sees its gnt bit.
  - It may keep req high in the following cycle only for a new read, and may change addr then.
  - A held req is never lost; the round-robin scan guarantees service within N_REQ cycles.
- Stage 1, end of T: on a grant, rf_sel <= addr[k], s1_owner <= k, s1_valid <= 1. With no grant, s1_valid <= 0 and rf_sel holds its value.
- Stage 2, cycle T+1:
  - rf_rdata is valid for rf_sel.
  - The result is computed with this priority:
    - rf_sel == 31 -> 0.
    - else wr_en && wr_addr == rf_sel -> wr_data (bypass).
    - else rf_rdata.
  - At the end of T+1, rsp_data <= result and rsp_valid <= one-hot(s1_owner) if s1_valid, else 0.
- Latency: exactly 2 cycles from gnt to rsp_valid. Throughput is 1 read per cycle.
- rsp_data holds its last value when rsp_valid = 0.
- A write to register 31 is never bypassed; register 31 always returns 0.
- A write in cycle T (before rf_sel updates) is not bypassed. The register file itself makes that write visible.
- Back-to-back grants to the same requester are legal if only that requester requests.
- Reset mid-operation:
  - In-flight stage-1 and stage-2 reads are discarded.
  - rsp_valid = 0 in the cycle after reset, and ptr returns to 0.

Test Plan:
- Single read: reset, then in cycle 1 set req=0001 and addr0=5 with the register file returning 0x1234 for r5 -> gnt=0001 in cycle 1, rf_sel=5 in cycle 2, rsp_valid=0001 and rsp_data=0x1234 in cycle 3.
- Round-robin: hold req=1111 with addr_i = 10+i for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, and so on; rsp_valid follows 2 cycles later; rf_sel follows 10, 11, 12, 13.
- Fairness after a skip: ptr=2, req=0011 -> gnt=0001 and ptr becomes 1. Next cycle req=0011 -> gnt=0010.
- Bypass: grant a read of r7 with rf_rdata=0xAAAA, and assert wr_en with wr_addr=7 and wr_data=0x5555 in the rf_sel=7 cycle -> rsp_data=0x5555. With wr_addr=8 instead -> rsp_data=0xAAAA.
- XZR: read r31 with rf_rdata=0xFFFF and wr_en, wr_addr=31, wr_data=0x9 -> rsp_data=0.
- Reset mid-flight: grant in cycle T and assert reset in T+1 -> rsp_valid=0 in T+2, rf_sel=0, and the next grant goes to requester 0 first.
